// File: rtl/wb_regfile.sv
// Write-back stage: commits MEM/WB results to the 31-entry integer register file, serves two bypassed read ports and counts retired instructions.
// Optional retire trace port enabled by defining WB_RETIRE_TRACE_EN; otherwise trace outputs are tied to zero.
module wb_regfile #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 64,
  parameter int CNT_W   = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [DATA_W-1:0]  wbpr_wb_write_back_data,
  input  logic [4:0]         wbpr_wb_write_back_addr,
  input  logic [PC_W-1:0]    wbpr_wb_now_pc,
  input  logic [INSTR_W-1:0] wbpr_wb_instruction,
  input  logic               wbpr_wb_stall,
  input  logic               wbpr_wb_is_write_rf,
  input  logic [4:0]         id_rs1_addr,
  input  logic [4:0]         id_rs2_addr,
  output logic [DATA_W-1:0]  id_rs1_data,
  output logic [DATA_W-1:0]  id_rs2_data,
  output logic [CNT_W-1:0]   instret,
  output logic               trace_valid,
  output logic [PC_W-1:0]    trace_pc,
  output logic [INSTR_W-1:0] trace_instr,
  output logic [4:0]         trace_rd,
  output logic [DATA_W-1:0]  trace_data
);

  logic              retire_p0;
  logic              wr_en_p0;
  logic [DATA_W-1:0] rf [1:31];
  logic [CNT_W-1:0]  instret_p1;

  // Stage p0: commit decision from the incoming WB bundle
  assign retire_p0 = !wbpr_wb_stall && (wbpr_wb_instruction != '0);
  assign wr_en_p0  = retire_p0 && wbpr_wb_is_write_rf && (wbpr_wb_write_back_addr != 5'd0);

  // x0 is hardwired to zero and wins over any bypass match
  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        addr,
    input logic              wr_en,
    input logic [4:0]        wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] rdata;
    rdata = '0;
    if (addr != 5'd0) begin
      if (wr_en && (addr == wr_addr)) rdata = wr_data;
      else                            rdata = stored;
    end
    return rdata;
  endfunction

  always_comb begin
    id_rs1_data = '0;
    id_rs2_data = '0;
    id_rs1_data = read_port(id_rs1_addr, wr_en_p0, wbpr_wb_write_back_addr,
                            wbpr_wb_write_back_data,
                            (id_rs1_addr == 5'd0) ? '0 : rf[id_rs1_addr]);
    id_rs2_data = read_port(id_rs2_addr, wr_en_p0, wbpr_wb_write_back_addr,
                            wbpr_wb_write_back_data,
                            (id_rs2_addr == 5'd0) ? '0 : rf[id_rs2_addr]);
  end

  // Stage p1: architectural state updated on the commit edge
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 1; i < 32; i++) rf[i] <= '0;
    end else if (wr_en_p0) begin
      rf[wbpr_wb_write_back_addr] <= wbpr_wb_write_back_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     instret_p1 <= '0;
    else if (retire_p0) instret_p1 <= instret_p1 + CNT_W'(1);
  end

  assign instret = instret_p1;

`ifdef WB_RETIRE_TRACE_EN
  logic               trace_vld_p1;
  logic [PC_W-1:0]    trace_pc_p1;
  logic [INSTR_W-1:0] trace_instr_p1;
  logic [4:0]         trace_rd_p1;
  logic [DATA_W-1:0]  trace_data_p1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      trace_vld_p1   <= 1'b0;
      trace_pc_p1    <= '0;
      trace_instr_p1 <= '0;
      trace_rd_p1    <= '0;
      trace_data_p1  <= '0;
    end else if (retire_p0) begin
      trace_vld_p1   <= 1'b1;
      trace_pc_p1    <= wbpr_wb_now_pc;
      trace_instr_p1 <= wbpr_wb_instruction;
      trace_rd_p1    <= wr_en_p0 ? wbpr_wb_write_back_addr : 5'd0;
      trace_data_p1  <= wr_en_p0 ? wbpr_wb_write_back_data : '0;
    end else begin
      trace_vld_p1   <= 1'b0;
    end
  end

  assign trace_valid = trace_vld_p1;
  assign trace_pc    = trace_pc_p1;
  assign trace_instr = trace_instr_p1;
  assign trace_rd    = trace_rd_p1;
  assign trace_data  = trace_data_p1;
`else
  // The PC only feeds the trace port, so it is intentionally sunk here
  logic unused_now_pc;
  assign unused_now_pc = ^wbpr_wb_now_pc;

  assign trace_valid = 1'b0;
  assign trace_pc    = '0;
  assign trace_instr = '0;
  assign trace_rd    = '0;
  assign trace_data  = '0;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: directed commits queue expected read/counter/trace values checked at negedge.
// Trace expectations follow WB_RETIRE_TRACE_EN; counter built 8 bits wide so wrap is reachable.
module tb_wb_regfile;
  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;
  localparam int CNT_W   = 8;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [DATA_W-1:0]  wb_data = '0;
  logic [4:0]         wb_addr = '0;
  logic [PC_W-1:0]    wb_pc = '0;
  logic [INSTR_W-1:0] wb_instr = '0;
  logic               wb_stall = 1'b0;
  logic               wb_we = 1'b0;
  logic [4:0]         rs1_addr = '0;
  logic [4:0]         rs2_addr = '0;
  logic [DATA_W-1:0]  rs1_data;
  logic [DATA_W-1:0]  rs2_data;
  logic [CNT_W-1:0]   instret;
  logic               trace_valid;
  logic [PC_W-1:0]    trace_pc;
  logic [INSTR_W-1:0] trace_instr;
  logic [4:0]         trace_rd;
  logic [DATA_W-1:0]  trace_data;

  wb_regfile #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wbpr_wb_write_back_data(wb_data), .wbpr_wb_write_back_addr(wb_addr),
    .wbpr_wb_now_pc(wb_pc), .wbpr_wb_instruction(wb_instr),
    .wbpr_wb_stall(wb_stall), .wbpr_wb_is_write_rf(wb_we),
    .id_rs1_addr(rs1_addr), .id_rs2_addr(rs2_addr),
    .id_rs1_data(rs1_data), .id_rs2_data(rs2_data),
    .instret(instret), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_rd(trace_rd), .trace_data(trace_data)
  );

  always #5 sys_clk = ~sys_clk;

  localparam int S_RS1 = 0, S_RS2 = 1, S_CNT = 2, S_TV = 3, S_TRD = 4, S_TDATA = 5, S_TPC = 6;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic expect_val(input int sel, input logic [63:0] e, input string n);
    chk_t c;
    c.cyc = cyc; c.sel = sel; c.exp = e; c.name = n;
    q.push_back(c);
  endtask

  // Monitor: pops every expectation belonging to the current cycle
  always @(negedge sys_clk) begin
    chk_t        c;
    logic [63:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      c = q.pop_front();
      case (c.sel)
        S_RS1:   act = rs1_data;
        S_RS2:   act = rs2_data;
        S_CNT:   act = 64'(instret);
        S_TV:    act = 64'(trace_valid);
        S_TRD:   act = 64'(trace_rd);
        S_TDATA: act = trace_data;
        default: act = trace_pc;
      endcase
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", c.name, act, c.exp, cyc);
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic st, input logic we,
                       input logic [4:0] a, input logic [63:0] d,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] pc = 64'h0);
    @(posedge sys_clk);
    #1;
    wb_instr = ins; wb_stall = st; wb_we = we; wb_addr = a; wb_data = d;
    rs1_addr = r1; rs2_addr = r2; wb_pc = pc;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(32'h0, 1'b0, 1'b0, 5'd0, 64'h0, r1, r2);
  endtask

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    expect_val(S_RS1, 64'h0, "reset_rs1_x5");
    expect_val(S_CNT, 64'h0, "reset_instret");
    expect_val(S_TV,  64'h0, "reset_trace_valid");

    // Write x5 and read it back through bypass, then from storage
    drive(32'h13, 1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd0, 64'h8000_0000);
    expect_val(S_RS1, 64'hDEAD_BEEF, "wr_bypass_x5");
    expect_val(S_RS2, 64'h0, "wr_rs2_x0");
    expect_val(S_CNT, 64'h0, "wr_instret_before");
    idle(5'd5, 5'd0);
    expect_val(S_RS1, 64'hDEAD_BEEF, "wr_stored_x5");
    expect_val(S_CNT, 64'h1, "wr_instret_after");
`ifdef WB_RETIRE_TRACE_EN
    expect_val(S_TV,    64'h1, "wr_trace_valid");
    expect_val(S_TRD,   64'h5, "wr_trace_rd");
    expect_val(S_TDATA, 64'hDEAD_BEEF, "wr_trace_data");
`endif

    // Both ports hit x7 in the write cycle
    drive(32'h13, 1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd7);
    expect_val(S_RS1, 64'h1234, "byp_rs1_x7");
    expect_val(S_RS2, 64'h1234, "byp_rs2_x7");
    idle(5'd7, 5'd5);
    expect_val(S_RS1, 64'h1234, "byp_stored_x7");
    expect_val(S_RS2, 64'hDEAD_BEEF, "byp_stored_x5");
    expect_val(S_CNT, 64'h2, "byp_instret");

    // Writes to x0 are discarded but still retire
    drive(32'h13, 1'b0, 1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd0);
    expect_val(S_RS1, 64'h0, "x0_same_rs1");
    expect_val(S_RS2, 64'h0, "x0_same_rs2");
    idle(5'd0, 5'd0);
    expect_val(S_RS1, 64'h0, "x0_next_rs1");
    expect_val(S_CNT, 64'h3, "x0_instret");
`ifdef WB_RETIRE_TRACE_EN
    expect_val(S_TV,    64'h1, "x0_trace_valid");
    expect_val(S_TRD,   64'h0, "x0_trace_rd");
    expect_val(S_TDATA, 64'h0, "x0_trace_data");
`endif

    // Stall then bubble: neither commits nor counts
    drive(32'h13, 1'b1, 1'b1, 5'd3, 64'h9, 5'd3, 5'd0);
    expect_val(S_RS1, 64'h0, "stall_no_bypass_x3");
    expect_val(S_CNT, 64'h3, "stall_instret");
    drive(32'h0, 1'b0, 1'b1, 5'd3, 64'h9, 5'd3, 5'd0);
    expect_val(S_RS1, 64'h0, "bubble_no_bypass_x3");
    expect_val(S_CNT, 64'h3, "bubble_instret_after_stall");
    idle(5'd3, 5'd0);
    expect_val(S_RS1, 64'h0, "bubble_x3_stored");
    expect_val(S_CNT, 64'h3, "bubble_instret");
    expect_val(S_TV,  64'h0, "bubble_trace_valid");

    // Retire with PC 0x8000_0004 writing x2
    drive(32'h0010_0113, 1'b0, 1'b1, 5'd2, 64'h3, 5'd0, 5'd0, 64'h8000_0004);
    idle(5'd2, 5'd0);
    expect_val(S_RS1, 64'h3, "tr_x2_stored");
    expect_val(S_CNT, 64'h4, "tr_instret");
`ifdef WB_RETIRE_TRACE_EN
    expect_val(S_TV,    64'h1, "tr_valid");
    expect_val(S_TRD,   64'h2, "tr_rd");
    expect_val(S_TDATA, 64'h3, "tr_data");
    expect_val(S_TPC,   64'h8000_0004, "tr_pc");
`else
    expect_val(S_TV,    64'h0, "tr_valid_tied");
    expect_val(S_TPC,   64'h0, "tr_pc_tied");
`endif
    idle(5'd0, 5'd0);
    expect_val(S_TV, 64'h0, "tr_valid_drop");
`ifdef WB_RETIRE_TRACE_EN
    expect_val(S_TRD, 64'h2, "tr_rd_hold");
`else
    expect_val(S_TRD, 64'h0, "tr_rd_tied");
`endif

    // Counter wrap: 4 + 251 = 255, one more wraps to 0
    for (int i = 0; i < 251; i++) drive(32'h13, 1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    expect_val(S_CNT, 64'hFF, "cnt_max");
    drive(32'h13, 1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    expect_val(S_CNT, 64'h0, "cnt_wrap");

    // Restore a count, then reset mid-cycle and drop a commit held in reset
    drive(32'h13, 1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    idle(5'd5, 5'd7);
    expect_val(S_CNT, 64'h1, "pre_reset_instret");
    idle(5'd5, 5'd7);
    #2 sys_rst_n = 1'b0;
    expect_val(S_RS1, 64'h0, "async_rst_x5");
    expect_val(S_RS2, 64'h0, "async_rst_x7");
    expect_val(S_CNT, 64'h0, "async_rst_instret");
    expect_val(S_TV,  64'h0, "async_rst_trace_valid");
    #1;
    wb_instr = 32'h13; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 64'h55;
    drive(32'h0, 1'b0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd0);
    sys_rst_n = 1'b1;
    expect_val(S_RS1, 64'h0, "rst_dropped_x9");
    expect_val(S_CNT, 64'h0, "rst_dropped_instret");

    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
